// File: rtl/input_fetch.sv
// Streams COUNTER0 words from a 1-cycle-latency SRAM read port into the PE array through a 2-entry skid buffer.
// Optional feature macro: INPUT_FETCH_STRIDE_EN adds STRIDE_I (address step, latched at start).
module input_fetch #(
  parameter int DW = 16,
  parameter int AW = 16
) (
  input  logic          CLK,
  input  logic          RSTL,
  input  logic          INPUT_FETCH,
  input  logic [7:0]    COUNTER0,
  input  logic [AW-1:0] RADDRX_I,
  input  logic [5:0]    INPUT_EN_CTRL_I,
`ifdef INPUT_FETCH_STRIDE_EN
  input  logic [7:0]    STRIDE_I,
`endif
  input  logic          module_busy,
  input  logic [DW-1:0] RDATAX,
  output logic [AW-1:0] RADDRX,
  output logic          RCEBX,
  output logic [DW-1:0] INPUT_DATA,
  output logic          INPUT_EN,
  output logic [5:0]    INPUT_EN_CTRL,
  output logic          INPUT_BUSY,
  output logic          INPUT_DONE
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [7:0]      count_q;
  logic [7:0]      issued_q;
  logic [5:0]      ctrl_q;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   step;
  logic            inflight_q;
  logic [DW-1:0]   skid_mem [2];
  logic            rd_ptr;
  logic            wr_ptr;
  logic [1:0]      occ;
  logic            start;
  logic            issue;
  logic            pop;
  logic            push;
  logic [2:0]      pending;

`ifdef INPUT_FETCH_STRIDE_EN
  logic [7:0]      stride_q;
  assign step = AW'(stride_q);
`else
  assign step = AW'(1);
`endif

  // A read is only issued if its word is guaranteed a free slot even if the consumer stalls next cycle.
  always_comb begin
    start   = (state == S_IDLE) & INPUT_FETCH;
    pop     = (occ != 2'd0) & ~module_busy;
    push    = inflight_q;
    pending = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    issue   = (state == S_READ) & ~module_busy & (pending < 3'd2);
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (INPUT_FETCH) state_next = (COUNTER0 != 8'd0) ? S_READ : S_DONE;
      end
      S_READ: begin
        if (issue && ((issued_q + 8'd1) == count_q)) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (!inflight_q && (occ == {1'b0, pop})) state_next = S_DONE;
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTL) begin
    if (!RSTL) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge CLK or negedge RSTL) begin
    if (!RSTL) begin
      count_q     <= '0;
      issued_q    <= '0;
      ctrl_q      <= '0;
      addr_q      <= '0;
      inflight_q  <= 1'b0;
      skid_mem[0] <= '0;
      skid_mem[1] <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      occ         <= '0;
`ifdef INPUT_FETCH_STRIDE_EN
      stride_q    <= '0;
`endif
    end else begin
      if (start) begin
        count_q  <= COUNTER0;
        addr_q   <= RADDRX_I;
        ctrl_q   <= INPUT_EN_CTRL_I;
        issued_q <= '0;
`ifdef INPUT_FETCH_STRIDE_EN
        stride_q <= STRIDE_I;
`endif
      end else if (issue) begin
        addr_q   <= addr_q + step;
        issued_q <= issued_q + 8'd1;
      end
      inflight_q <= issue;
      if (push) begin
        skid_mem[wr_ptr] <= RDATAX;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  always_comb begin
    RADDRX        = addr_q;
    RCEBX         = ~issue;
    INPUT_DATA    = skid_mem[rd_ptr];
    INPUT_EN      = pop;
    INPUT_EN_CTRL = pop ? ctrl_q : 6'd0;
    INPUT_BUSY    = (state != S_IDLE);
    INPUT_DONE    = (state == S_DONE);
  end

endmodule

// File: tb/tb_input_fetch.sv
// Bench for input_fetch: emulated SRAM, directed and random transfers checked against address/data expectations.
module tb_input_fetch;

  logic        CLK;
  logic        RSTL;
  logic        INPUT_FETCH;
  logic [7:0]  COUNTER0;
  logic [15:0] RADDRX_I;
  logic [5:0]  INPUT_EN_CTRL_I;
`ifdef INPUT_FETCH_STRIDE_EN
  logic [7:0]  STRIDE_I;
`endif
  logic        module_busy;
  logic [15:0] RDATAX;
  logic [15:0] RADDRX;
  logic        RCEBX;
  logic [15:0] INPUT_DATA;
  logic        INPUT_EN;
  logic [5:0]  INPUT_EN_CTRL;
  logic        INPUT_BUSY;
  logic        INPUT_DONE;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] salt = 16'h0;

  input_fetch #(.DW(16), .AW(16)) dut (
    .CLK(CLK),
    .RSTL(RSTL),
    .INPUT_FETCH(INPUT_FETCH),
    .COUNTER0(COUNTER0),
    .RADDRX_I(RADDRX_I),
    .INPUT_EN_CTRL_I(INPUT_EN_CTRL_I),
`ifdef INPUT_FETCH_STRIDE_EN
    .STRIDE_I(STRIDE_I),
`endif
    .module_busy(module_busy),
    .RDATAX(RDATAX),
    .RADDRX(RADDRX),
    .RCEBX(RCEBX),
    .INPUT_DATA(INPUT_DATA),
    .INPUT_EN(INPUT_EN),
    .INPUT_EN_CTRL(INPUT_EN_CTRL),
    .INPUT_BUSY(INPUT_BUSY),
    .INPUT_DONE(INPUT_DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [15:0] word_of(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C ^ salt;
  endfunction

  // SRAM contents are a fixed function of address; unread cycles return noise.
  always @(posedge CLK) begin
    if (!RCEBX) RDATAX <= word_of(RADDRX);
    else        RDATAX <= 16'($urandom);
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_raddr"}, 32'(RADDRX), 32'h0);
    check_output({tag, "_rceb"}, 32'(RCEBX), 32'h1);
    check_output({tag, "_data"}, 32'(INPUT_DATA), 32'h0);
    check_output({tag, "_en"}, 32'(INPUT_EN), 32'h0);
    check_output({tag, "_ctrl"}, 32'(INPUT_EN_CTRL), 32'h0);
    check_output({tag, "_busy"}, 32'(INPUT_BUSY), 32'h0);
    check_output({tag, "_done"}, 32'(INPUT_DONE), 32'h0);
  endtask

  // mode 0: never stalled, 1: random stalls, 2: stall for three cycles mid-stream
  task automatic apply_stimulus(input int cnt, input logic [15:0] base, input logic [5:0] ctrl,
                                input logic [7:0] stride, input int mode, input bit poke);
    logic [15:0] step;
    logic [15:0] ea;
    logic [15:0] got_addr[$];
    logic [15:0] got_word[$];
    int idx;
    int first_en;
    int last_en;
    int done_idx;
    int done_cnt;
`ifdef INPUT_FETCH_STRIDE_EN
    step = {8'h00, stride};
`else
    step = 16'd1;
`endif
    $display("[TB] transfer count=%0d base=%h stride=%0d mode=%0d", cnt, base, stride, mode);
    salt = 16'($urandom);
    @(negedge CLK);
    INPUT_FETCH     = 1'b1;
    COUNTER0        = cnt[7:0];
    RADDRX_I        = base;
    INPUT_EN_CTRL_I = ctrl;
`ifdef INPUT_FETCH_STRIDE_EN
    STRIDE_I        = stride;
`endif
    module_busy     = 1'b0;
    @(negedge CLK);
    INPUT_FETCH     = 1'b0;
    COUNTER0        = 8'($urandom);
    RADDRX_I        = 16'($urandom);
    INPUT_EN_CTRL_I = 6'($urandom);
`ifdef INPUT_FETCH_STRIDE_EN
    STRIDE_I        = 8'($urandom);
`endif
    idx = 0; first_en = -1; last_en = -1; done_idx = -1; done_cnt = 0;
    while (idx < 3000 && !(done_idx >= 0 && idx > done_idx + 2)) begin
      case (mode)
        0:       module_busy = 1'b0;
        1:       module_busy = ($urandom_range(0, 9) < 3);
        default: module_busy = (idx >= 4 && idx <= 6);
      endcase
      if (poke) INPUT_FETCH = (idx == 3);
      #1;
      if (!RCEBX) got_addr.push_back(RADDRX);
      if (INPUT_EN) begin
        got_word.push_back(INPUT_DATA);
        if (first_en < 0) first_en = idx;
        last_en = idx;
      end
      if (INPUT_DONE) begin
        done_cnt++;
        if (done_idx < 0) done_idx = idx;
      end
      check_output("read_while_busy", 32'(!RCEBX && module_busy), 32'h0);
      check_output("en_while_busy", 32'(INPUT_EN && module_busy), 32'h0);
      check_output("en_ctrl", 32'(INPUT_EN_CTRL), INPUT_EN ? 32'(ctrl) : 32'h0);
      check_output("input_busy", 32'(INPUT_BUSY), 32'(done_idx < 0 || idx == done_idx));
      idx++;
      @(negedge CLK);
    end
    module_busy = 1'b0;
    INPUT_FETCH = 1'b0;
    check_output("done_seen", 32'(done_idx >= 0), 32'h1);
    check_output("done_count", 32'(done_cnt), 32'h1);
    check_output("addr_count", 32'(got_addr.size()), 32'(cnt));
    for (int i = 0; i < got_addr.size() && i < cnt; i++) begin
      ea = base + 16'(i) * step;
      check_output("addr", 32'(got_addr[i]), 32'(ea));
    end
    check_output("word_count", 32'(got_word.size()), 32'(cnt));
    for (int i = 0; i < got_word.size() && i < cnt; i++) begin
      ea = base + 16'(i) * step;
      check_output("word", 32'(got_word[i]), 32'(word_of(ea)));
    end
    if (cnt == 0) check_output("empty_done_idx", 32'(done_idx), 32'h0);
    else          check_output("done_after_last", 32'(done_idx), 32'(last_en + 1));
    if (mode == 0 && cnt > 0) begin
      check_output("first_en_latency", 32'(first_en), 32'd2);
      check_output("back_to_back", 32'(last_en - first_en), 32'(cnt - 1));
    end
  endtask

  initial begin
    RSTL            = 1'b0;
    INPUT_FETCH     = 1'b0;
    COUNTER0        = 8'd0;
    RADDRX_I        = 16'd0;
    INPUT_EN_CTRL_I = 6'd0;
`ifdef INPUT_FETCH_STRIDE_EN
    STRIDE_I        = 8'd1;
`endif
    module_busy     = 1'b0;
    #1;
    check_reset_values("por");
    repeat (2) @(negedge CLK);
    RSTL = 1'b1;
    @(negedge CLK);
    check_reset_values("idle");

    apply_stimulus(4, 16'h0100, 6'h2A, 8'd1, 0, 1'b0);
    apply_stimulus(0, 16'h0200, 6'h15, 8'd1, 0, 1'b0);
    apply_stimulus(8, 16'h0300, 6'h3F, 8'd1, 2, 1'b0);
    apply_stimulus(4, 16'hFFFE, 6'h01, 8'd1, 0, 1'b0);
    apply_stimulus(3, 16'h0010, 6'h07, 8'd3, 0, 1'b0);
    apply_stimulus(6, 16'h0400, 6'h11, 8'd1, 1, 1'b1);

    // Abort a transfer with reset and confirm the next one is clean.
    @(negedge CLK);
    INPUT_FETCH = 1'b1;
    COUNTER0    = 8'd8;
    RADDRX_I    = 16'h0500;
    @(negedge CLK);
    INPUT_FETCH = 1'b0;
    repeat (3) @(negedge CLK);
    RSTL = 1'b0;
    #1;
    check_reset_values("abort");
    @(negedge CLK);
    RSTL = 1'b1;
    apply_stimulus(5, 16'h0600, 6'h22, 8'd1, 0, 1'b0);

    for (int t = 0; t < 12; t++) begin
      int cnt;
      cnt = $urandom_range(0, 20);
      apply_stimulus(cnt, 16'($urandom), 6'($urandom), 8'($urandom_range(0, 7)),
                     1, (cnt >= 4) && ($urandom_range(0, 1) == 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
